// File: rtl/spike_generator_array.sv
// -----------------------------------------------------------------------------
// spike_generator_array
//
// Bank of 2^Ngens programmable periodic spike sources. Each time-unit pulse
// triggers one ascending scan of generators 0..gens_used. An enabled
// generator with a nonzero period whose countdown has reached zero emits one
// {tag, +1/-1} word and reloads its countdown with period-1. Otherwise its
// countdown decrements.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   time_unit_pulse   one-cycle strobe at each FPGA time-unit boundary
//   gens_used         highest generator index scanned
//   gens_en           per-generator enable, sampled live during the scan
//   prog_*            programming channel (v/a). One word overwrites a
//                     whole table entry {period, ticks, tag, sign}.
//   out_tag, out_ct   emitted word (count is +1 or -1, two's complement)
//   out_v, out_a      output channel (v/a)
//   overrun           sticky: a time-unit pulse was dropped
//
// Handshake (both channels): a word transfers on the clk edge where v && a
// are both high. The source holds v and its data stable until that edge.
// -----------------------------------------------------------------------------
module spike_generator_array #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    time_unit_pulse,
    input  logic [Ngens-1:0]        gens_used,
    input  logic [(1<<Ngens)-1:0]   gens_en,
    input  logic [Ngens-1:0]        prog_gen_idx,
    input  logic [Nperiod-1:0]      prog_period,
    input  logic [Nperiod-1:0]      prog_ticks,
    input  logic [Ntag-1:0]         prog_tag,
    input  logic                    prog_sign,
    input  logic                    prog_v,
    output logic                    prog_a,
    output logic [Ntag-1:0]         out_tag,
    output logic [Nct-1:0]          out_ct,
    output logic                    out_v,
    input  logic                    out_a,
    output logic                    overrun
);

    localparam int NumGens = 1 << Ngens;
    localparam logic [Nperiod-1:0] PeriodOne = 1;
    localparam logic [Ngens-1:0]   IdxOne    = 1;
    localparam logic [Nct-1:0]     CtOne     = 1;

    typedef enum logic [1:0] {IDLE, READ, EVAL, EMIT} state_t;

    state_t           state, state_next;
    logic [Ngens-1:0] idx, idx_next;
    logic             pending;

    // Table storage. Only the valid bits are reset; an invalid entry is
    // treated as period 0 (inert), so the RAM arrays need no reset.
    logic [NumGens-1:0] ent_valid;
    logic [Nperiod-1:0] period_mem [NumGens];
    logic [Nperiod-1:0] ticks_mem  [NumGens];
    logic [Ntag-1:0]    tag_mem    [NumGens];
    logic               sign_mem   [NumGens];

    // Entry captured in READ, used in EVAL.
    logic               rd_valid;
    logic [Nperiod-1:0] rd_period;
    logic [Nperiod-1:0] rd_ticks;
    logic [Ntag-1:0]    rd_tag;
    logic               rd_sign;

    logic               scan_start;
    logic               scan_last;
    logic               tick_we;
    logic [Nperiod-1:0] tick_wdata;
    logic               out_load;
    logic               out_clear;
    logic               prog_fire;

    assign prog_a    = (state == IDLE) && !pending && !reset;
    assign prog_fire = prog_v && prog_a;
    assign scan_last = (idx == gens_used);

    always_comb begin
        state_next = state;
        idx_next   = idx;
        scan_start = 1'b0;
        tick_we    = 1'b0;
        tick_wdata = '0;
        out_load   = 1'b0;
        out_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (pending || time_unit_pulse) begin
                    scan_start = 1'b1;
                    idx_next   = '0;
                    state_next = READ;
                end
            end
            READ: state_next = EVAL;
            EVAL: begin
                if (gens_en[idx] && rd_valid && (rd_period != '0) && (rd_ticks == '0)) begin
                    tick_we    = 1'b1;
                    tick_wdata = rd_period - PeriodOne;
                    out_load   = 1'b1;
                    state_next = EMIT;
                end else begin
                    if (gens_en[idx] && rd_valid && (rd_period != '0)) begin
                        tick_we    = 1'b1;
                        tick_wdata = rd_ticks - PeriodOne;
                    end
                    if (scan_last) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + IdxOne;
                        state_next = READ;
                    end
                end
            end
            EMIT: begin
                if (out_a) begin
                    out_clear = 1'b1;
                    if (scan_last) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + IdxOne;
                        state_next = READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            ent_valid <= '0;
            out_v     <= 1'b0;
            out_tag   <= '0;
            out_ct    <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;

            // A scan start consumes the pending pulse; a pulse arriving in
            // that same cycle becomes the new pending one. A pulse that finds
            // pending already set (and not being consumed) is lost.
            if (scan_start) begin
                pending <= pending && time_unit_pulse;
            end else if (time_unit_pulse) begin
                if (pending) begin
                    overrun <= 1'b1;
                end
                pending <= 1'b1;
            end

            if (prog_fire) begin
                ent_valid[prog_gen_idx] <= 1'b1;
            end

            if (out_load) begin
                out_v   <= 1'b1;
                out_tag <= rd_tag;
                out_ct  <= rd_sign ? '1 : CtOne;
            end else if (out_clear) begin
                out_v <= 1'b0;
            end
        end
    end

    // RAM-style storage: writes are suppressed during reset so an aborted
    // scan leaves no partial write-back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (prog_fire) begin
                period_mem[prog_gen_idx] <= prog_period;
                ticks_mem[prog_gen_idx]  <= prog_ticks;
                tag_mem[prog_gen_idx]    <= prog_tag;
                sign_mem[prog_gen_idx]   <= prog_sign;
            end else if (tick_we) begin
                ticks_mem[idx] <= tick_wdata;
            end
        end
        if (state == READ) begin
            rd_valid  <= ent_valid[idx];
            rd_period <= period_mem[idx];
            rd_ticks  <= ticks_mem[idx];
            rd_tag    <= tag_mem[idx];
            rd_sign   <= sign_mem[idx];
        end
    end

endmodule

// File: tb/tb_spike_generator_array.sv
module tb_spike_generator_array;

    localparam int Ngens   = 8;
    localparam int Nperiod = 16;
    localparam int Ntag    = 11;
    localparam int Nct     = 9;
    localparam int W       = Ntag + Nct;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   time_unit_pulse = 1'b0;
    logic [Ngens-1:0]       gens_used = '0;
    logic [(1<<Ngens)-1:0]  gens_en = '0;
    logic [Ngens-1:0]       prog_gen_idx = '0;
    logic [Nperiod-1:0]     prog_period = '0;
    logic [Nperiod-1:0]     prog_ticks = '0;
    logic [Ntag-1:0]        prog_tag = '0;
    logic                   prog_sign = 1'b0;
    logic                   prog_v = 1'b0;
    logic                   prog_a;
    logic [Ntag-1:0]        out_tag;
    logic [Nct-1:0]         out_ct;
    logic                   out_v;
    logic                   out_a = 1'b0;
    logic                   overrun;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    spike_generator_array #(
        .Ngens(Ngens), .Nperiod(Nperiod), .Ntag(Ntag), .Nct(Nct)
    ) dut (
        .clk(clk), .reset(reset), .time_unit_pulse(time_unit_pulse),
        .gens_used(gens_used), .gens_en(gens_en),
        .prog_gen_idx(prog_gen_idx), .prog_period(prog_period),
        .prog_ticks(prog_ticks), .prog_tag(prog_tag), .prog_sign(prog_sign),
        .prog_v(prog_v), .prog_a(prog_a),
        .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v), .out_a(out_a),
        .overrun(overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic program_gen(input logic [Ngens-1:0] g, input logic [Nperiod-1:0] p,
                               input logic [Nperiod-1:0] t, input logic [Ntag-1:0] tg,
                               input logic s);
        bit ok;
        ok = 1'b0;
        prog_gen_idx = g;
        prog_period  = p;
        prog_ticks   = t;
        prog_tag     = tg;
        prog_sign    = s;
        prog_v       = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prog_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        prog_v = 1'b0;
        check("prog_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_only();
        time_unit_pulse = 1'b1;
        tick();
        time_unit_pulse = 1'b0;
    endtask

    // Pulse in cycle t; out_v must be low in t+2 and equal `fires` in t+3.
    task automatic pulse_check(input bit fires, input logic [Ntag-1:0] tg, input logic [Nct-1:0] ct);
        if (fires) exp_q.push_back({tg, ct});
        pulse_only();
        @(negedge clk);
        @(negedge clk);
        check("out_v_t2", {31'd0, out_v}, 32'd0);
        @(negedge clk);
        check("out_v_t3", {31'd0, out_v}, {31'd0, fires});
        repeat (4) tick();
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- scoreboard monitor ----------------
    logic         stall_seen = 1'b0;
    logic [W-1:0] stall_word = '0;
    logic [W-1:0] got_word;
    logic [W-1:0] exp_word;

    always @(negedge clk) begin
        if (stall_seen && reset === 1'b0) begin
            checks++;
            if (out_v !== 1'b1 || {out_tag, out_ct} !== stall_word) begin
                errors++;
                $display("FAIL out_hold actual=v%0b/%0h required=v1/%0h", out_v, {out_tag, out_ct}, stall_word);
            end
        end
        if (out_v === 1'b1 && out_a === 1'b1) begin
            got_word = {out_tag, out_ct};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none", got_word);
            end else begin
                exp_word = exp_q.pop_front();
                if (got_word !== exp_word) begin
                    errors++;
                    $display("FAIL out_word actual=%0h required=%0h", got_word, exp_word);
                end
            end
        end
        stall_seen = (out_v === 1'b1 && out_a === 1'b0 && reset === 1'b0);
        stall_word = {out_tag, out_ct};
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        tick();
        @(negedge clk);
        check("rst_prog_a", {31'd0, prog_a}, 32'd0);
        check("rst_out_v", {31'd0, out_v}, 32'd0);
        check("rst_out_tag", {21'd0, out_tag}, 32'd0);
        check("rst_out_ct", {23'd0, out_ct}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("idle_prog_a", {31'd0, prog_a}, 32'd1);
        tick();

        // Test 1: period 3, ticks 0, +1 -> fires at pulses 1, 4, 7
        gens_used = '0;
        gens_en = '0;
        gens_en[0] = 1'b1;
        out_a = 1'b1;
        program_gen(8'd0, 16'd3, 16'd0, 11'h005, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            pulse_check((i % 3) == 1, 11'h005, 9'h001);
        end
        check_drained("t1_drained");

        // Test 2: ticks 2, sign 1 -> first word at pulse 3, count -1
        do_reset();
        program_gen(8'd0, 16'd3, 16'd2, 11'h005, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            pulse_check(i == 3, 11'h005, 9'h1FF);
        end
        check_drained("t2_drained");

        // Test 3: two generators, output stalled for 5 cycles
        do_reset();
        gens_used = 8'd1;
        gens_en[1] = 1'b1;
        out_a = 1'b0;
        program_gen(8'd0, 16'd1, 16'd0, 11'h00A, 1'b0);
        program_gen(8'd1, 16'd1, 16'd0, 11'h00B, 1'b0);
        exp_q.push_back({11'h00A, 9'h001});
        exp_q.push_back({11'h00B, 9'h001});
        pulse_only();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_v", {31'd0, out_v}, 32'd1);
            check("t3_stall_tag", {21'd0, out_tag}, 32'h00A);
        end
        tick();
        out_a = 1'b1;
        repeat (12) tick();
        check_drained("t3_drained");

        // Test 4: pulses during a stalled scan; third one is dropped
        do_reset();
        gens_used = '0;
        gens_en[1] = 1'b0;
        out_a = 1'b0;
        program_gen(8'd0, 16'd1, 16'd0, 11'h0C0, 1'b0);
        exp_q.push_back({11'h0C0, 9'h001});
        exp_q.push_back({11'h0C0, 9'h001});
        pulse_only();
        tick();
        pulse_only();
        @(negedge clk);
        check("t4_no_overrun_yet", {31'd0, overrun}, 32'd0);
        tick();
        pulse_only();
        @(negedge clk);
        check("t4_overrun_set", {31'd0, overrun}, 32'd1);
        tick();
        out_a = 1'b1;
        repeat (20) tick();
        check_drained("t4_two_scans");
        @(negedge clk);
        check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
        check("t4_out_v_idle", {31'd0, out_v}, 32'd0);
        tick();
        do_reset();
        @(negedge clk);
        check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
        tick();

        // Test 5: disable for 4 pulses, ticks frozen, then resume
        program_gen(8'd0, 16'd2, 16'd0, 11'h033, 1'b0);
        pulse_check(1'b1, 11'h033, 9'h001);
        pulse_check(1'b0, 11'h033, 9'h001);
        gens_en[0] = 1'b0;
        for (int i = 0; i < 4; i++) pulse_check(1'b0, 11'h033, 9'h001);
        gens_en[0] = 1'b1;
        pulse_check(1'b1, 11'h033, 9'h001);
        pulse_check(1'b0, 11'h033, 9'h001);
        pulse_check(1'b1, 11'h033, 9'h001);
        check_drained("t5_drained");
        // Programming word offered mid-scan waits for IDLE
        pulse_only();
        prog_gen_idx = 8'd0;
        prog_period  = 16'd1;
        prog_ticks   = 16'd0;
        prog_tag     = 11'h044;
        prog_sign    = 1'b0;
        prog_v       = 1'b1;
        @(negedge clk);
        check("t5_prog_a_read", {31'd0, prog_a}, 32'd0);
        @(negedge clk);
        check("t5_prog_a_eval", {31'd0, prog_a}, 32'd0);
        @(negedge clk);
        check("t5_prog_a_idle", {31'd0, prog_a}, 32'd1);
        tick();
        prog_v = 1'b0;
        pulse_check(1'b1, 11'h044, 9'h001);
        check_drained("t5_reprog");

        // Test 6: reset while in EMIT
        out_a = 1'b0;
        pulse_only();
        repeat (3) @(negedge clk);
        check("t6_emit_v", {31'd0, out_v}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_out_v", {31'd0, out_v}, 32'd0);
        check("t6_rst_out_tag", {21'd0, out_tag}, 32'd0);
        check("t6_rst_prog_a", {31'd0, prog_a}, 32'd1);
        tick();
        out_a = 1'b1;
        pulse_check(1'b0, 11'h000, 9'h000);
        pulse_check(1'b0, 11'h000, 9'h000);
        check_drained("t6_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_generator_array.md
Name: spike_generator_array

Overview:
- Bank of up to 2^Ngens programmable periodic spike sources.
- Each source emits a tag with a count of +1 or -1 once every `period` FPGA time units.
- Sits directly upstream of the tag/count merge into the BD-bound path.
  - Input: generator programming words plus the time-unit pulse from the time manager.
  - Output: a tag/count channel using the standard v/a handshake.

Parameters:
Ngens, 8, generator index width; the table holds 2^Ngens entries
Nperiod, 16, period and tick-counter width
Ntag, 11, emitted tag width
Nct, 9, emitted count width, two's complement

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
time_unit_pulse  in  1  one-cycle strobe at each FPGA time-unit boundary
gens_used  in  Ngens  highest generator index scanned
gens_en  in  2^Ngens  per-generator enable
prog_gen_idx  in  Ngens  generator being programmed
prog_period  in  Nperiod  emission period in time units; 0 = generator inert
prog_ticks  in  Nperiod  initial countdown
prog_tag  in  Ntag  tag to emit
prog_sign  in  1  1 = emit -1, 0 = emit +1
prog_v  in  1  programming word valid
prog_a  out  1  programming word accepted
out_tag  out  Ntag  emitted tag
out_ct  out  Nct  emitted count
out_v  out  1  output valid
out_a  in  1  output accepted
overrun  out  1  sticky: a time unit was dropped

Behaviour:
- Handshake, both channels: transfer occurs on a clk edge where v && a. A source must hold v and data stable until the transfer.
- Table entry: {period, ticks, tag, sign}. Storage may be RAM with 1-cycle read.
- Reset:
  - Outputs: out_v=0, out_tag=0, out_ct=0, prog_a=0, overrun=0.
  - FSM goes to IDLE; pending=0.
  - Every entry's period is cleared to 0, so all generators are inert. A per-entry valid bit is acceptable.
- prog_a = (state==IDLE) && !pending && !reset. This is combinational.
  - An accepted word overwrites the entire entry at prog_gen_idx.
  - A word presented mid-scan waits, with prog_a low, until IDLE.
- pending flag:
  - Set on time_unit_pulse; cleared when a scan starts.
  - A pulse that arrives while pending is already 1 is dropped and sets overrun. overrun is cleared only by reset.
  - A pulse in the same cycle a scan starts leaves pending=1.
- FSM states: IDLE, READ, EVAL, EMIT.
  - IDLE: if pending (or time_unit_pulse this cycle) -> READ with idx=0; clear pending.
  - READ: issue a table read at idx -> EVAL.
  - EVAL, with entry e:
    - If !gens_en[idx] or e.period==0: no change, go to NEXT.
    - Else if e.ticks==0: write ticks=e.period-1, load out_tag=e.tag and out_ct=(e.sign ? all-ones : 1), set out_v=1 -> EMIT.
    - Else: write ticks=e.ticks-1, go to NEXT.
  - EMIT: hold out_v and data. When out_a is high, clear out_v next cycle and go to NEXT.
  - NEXT: if idx==gens_used -> IDLE; else idx+1 -> READ.
- Latency: with the FSM in IDLE and a pulse in cycle t, out_v for a firing gen 0 is high in cycle t+3.
- Scan order: ascending idx. At most one output word per generator per time unit.
- Period p: fires every p time units. period=1 fires every unit.
- prog_ticks=k: first emission at the (k+1)th scan.
- gens_en or gens_used changes take effect at the next EVAL/NEXT decision; they are not latched per scan.
- idx wraps never: the scan stops at gens_used ≤ 2^Ngens-1.
- Synchronous reset mid-scan or mid-EMIT:
  - Scan aborted; out_v=0 after the edge.
  - No partial write-back.
  - pending cleared.

Test Plan:
- Gen 0: period=3, ticks=0, tag=0x005, sign=0; gens_used=0, en[0]=1; 7 pulses, out_a=1 -> 3 words (tag 0x005, ct 0x001) at pulses 1, 4, 7; out_v rises 3 cycles after each pulse.
- Same setup with sign=1, ticks=2 -> first word at pulse 3, ct=0x1FF.
- Gens 0 and 1, both period=1, tags 0x00A/0x00B, out_a held low 5 cycles -> out_v and 0x00A held stable; after acceptance 0x00B follows; no loss, no duplication.
- Pulse during a stalled scan, then a third pulse while pending -> exactly 2 scans total; overrun=1 and stays set until reset.
- Disable en[0] for 4 pulses (period=2), then re-enable -> no words while disabled; cadence resumes from the frozen ticks value. prog_v during a scan -> prog_a=0 until IDLE.
- Reset asserted in EMIT -> out_v=0 next cycle; subsequent pulses produce no words until reprogrammed; prog_a=1 in IDLE.
